// File: rtl/usb_pkg.sv
// Shared definitions for the USB transmit path: controller states, fixed
// field values and CRC16 constants.
package usb_pkg;

    // Clocks per USB bit time used when the instantiating level does not override it.
    localparam int DEFAULT_BIT_CLKS = 8;

    // SYNC field, transmitted LSB first (seven zeros then a one).
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // USB CRC16 generator polynomial (normal form) and preset value.
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Index of the final bit within each serialized field.
    localparam logic [3:0] BYTE_LAST_IDX = 4'd7;
    localparam logic [3:0] CRC_LAST_IDX  = 4'd15;
    localparam logic [3:0] EOP_LAST_IDX  = 4'd2;

    // Transmit controller states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_EOP,
        ST_EOP_WAIT
    } tx_state_e;

    // PID byte on the wire: check nibble (inverted PID) above the PID itself.
    function automatic logic [7:0] pid_byte(input logic [3:0] pid_val);
        return {~pid_val, pid_val};
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Bit-serial USB CRC16 register. Kept in normal (MSB-first) orientation so
// the transmitted check bits come out of bit 15 downward; this equals the
// reflected USB formulation sent LSB first.
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        enable,
    input  logic        data_bit,
    output logic [15:0] crc
);

    logic [15:0] crc_reg;
    logic [15:0] crc_next;
    logic        feedback;

    // Incoming bit is compared with the register MSB; a mismatch folds in the polynomial.
    assign feedback    = crc_reg[15] ^ data_bit;
    assign crc_next[0] = feedback & CRC16_POLY[0];

    genvar gi;
    generate
        for (gi = 1; gi < 16; gi++) begin : g_crc_bit
            assign crc_next[gi] = crc_reg[gi-1] ^ (feedback & CRC16_POLY[gi]);
        end
    endgenerate

    // Preset on clear, otherwise advance by one payload bit when enabled.
    always_ff @(posedge clk) begin
        if (clear) begin
            crc_reg <= CRC16_INIT;
        end else if (enable) begin
            crc_reg <= crc_next;
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/usb_tx_controller.sv
// USB packet transmit controller: serializes SYNC, PID, optional payload
// and CRC16 as NRZ bits towards a bit-stuffing encoder, then requests EOP.
// Every output is registered; a bit is offered on tx_out_bit for a whole bit
// time and tx_shift marks the clock the encoder takes it.
module usb_tx_controller
    import usb_pkg::*;
#(
    parameter int BIT_CLKS = DEFAULT_BIT_CLKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] pid,
    input  logic       has_data,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    input  logic       tx_hold,
    output logic       tx_out_bit,
    output logic       tx_shift,
    output logic       create_eop,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam logic [7:0] TIMER_MAX = 8'(BIT_CLKS - 1);

    tx_state_e   state_reg;
    logic [7:0]  timer_reg;
    logic [3:0]  bit_idx_reg;
    logic [6:0]  shift_reg;       // bits of the current field still to be sent
    logic [3:0]  pid_reg;
    logic        has_data_reg;
    logic        last_reg;        // byte being shifted carried byte_last
    logic        tx_out_bit_reg;
    logic        tx_shift_reg;
    logic        byte_ready_reg;
    logic        create_eop_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        underrun_reg;

    logic        in_bit_state;
    logic        bit_expire;
    logic        start_accept;
    logic        load_point;
    logic        crc_clear;
    logic        crc_enable;
    logic [15:0] crc_value;
    logic [7:0]  pid_tx_byte;
    logic [7:0]  sync_tx_byte;

    assign in_bit_state = (state_reg != ST_IDLE) && (state_reg != ST_EOP_WAIT);
    assign bit_expire   = in_bit_state && (timer_reg == TIMER_MAX);
    assign start_accept = (state_reg == ST_IDLE) && start;
    assign pid_tx_byte  = pid_byte(pid_reg);
    assign sync_tx_byte = SYNC_BYTE;

    // A new payload byte is fetched whenever the last bit of the PID (data
    // packets) or of a non-final payload byte is handed to the encoder.
    assign load_point = (bit_idx_reg == BYTE_LAST_IDX) &&
                        (((state_reg == ST_PID) && has_data_reg) ||
                         ((state_reg == ST_DATA) && !last_reg));

    // CRC covers payload bits only; each bit is folded in on the clock the
    // encoder accepts it, so the final value is ready before CRC state starts.
    assign crc_clear  = rst || start_accept;
    assign crc_enable = (state_reg == ST_DATA) && bit_expire && !tx_hold;

    usb_crc16 u_crc16 (
        .clk      (clk),
        .clear    (crc_clear),
        .enable   (crc_enable),
        .data_bit (tx_out_bit_reg),
        .crc      (crc_value)
    );

    // Packet sequencer: bit timer, field serialization and state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            timer_reg      <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            pid_reg        <= '0;
            has_data_reg   <= 1'b0;
            last_reg       <= 1'b0;
            tx_out_bit_reg <= 1'b1;
            tx_shift_reg   <= 1'b0;
            byte_ready_reg <= 1'b0;
            create_eop_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            tx_shift_reg   <= 1'b0;
            byte_ready_reg <= 1'b0;
            create_eop_reg <= 1'b0;
            done_reg       <= 1'b0;
            underrun_reg   <= 1'b0;

            // Bit timer runs continuously across field boundaries so every
            // bit, including the EOP slots, lasts exactly one bit time. A
            // held expiry just restarts the timer with the bit unchanged.
            if (in_bit_state) begin
                if (bit_expire) begin
                    timer_reg <= '0;
                    if (!tx_hold) begin
                        tx_shift_reg <= 1'b1;
                        if (load_point) begin
                            byte_ready_reg <= 1'b1;
                        end
                    end
                end else begin
                    timer_reg <= timer_reg + 8'd1;
                end
            end

            // Field handling happens on the clock after tx_shift, which is
            // when the next bit is placed on tx_out_bit.
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg      <= ST_SYNC;
                        timer_reg      <= '0;
                        bit_idx_reg    <= '0;
                        busy_reg       <= 1'b1;
                        pid_reg        <= pid;
                        has_data_reg   <= has_data;
                        last_reg       <= 1'b0;
                        shift_reg      <= sync_tx_byte[7:1];
                        tx_out_bit_reg <= sync_tx_byte[0];
                    end
                end

                ST_SYNC: begin
                    if (tx_shift_reg) begin
                        if (bit_idx_reg == BYTE_LAST_IDX) begin
                            state_reg      <= ST_PID;
                            bit_idx_reg    <= '0;
                            shift_reg      <= pid_tx_byte[7:1];
                            tx_out_bit_reg <= pid_tx_byte[0];
                        end else begin
                            bit_idx_reg    <= bit_idx_reg + 4'd1;
                            shift_reg      <= {1'b1, shift_reg[6:1]};
                            tx_out_bit_reg <= shift_reg[0];
                        end
                    end
                end

                ST_PID, ST_DATA: begin
                    if (tx_shift_reg) begin
                        if (bit_idx_reg != BYTE_LAST_IDX) begin
                            bit_idx_reg    <= bit_idx_reg + 4'd1;
                            shift_reg      <= {1'b1, shift_reg[6:1]};
                            tx_out_bit_reg <= shift_reg[0];
                        end else if ((state_reg == ST_PID) && !has_data_reg) begin
                            // PID-only packet: straight to end of packet.
                            state_reg      <= ST_EOP;
                            bit_idx_reg    <= '0;
                            create_eop_reg <= 1'b1;
                            tx_out_bit_reg <= 1'b1;
                        end else if ((state_reg == ST_DATA) && last_reg) begin
                            // Final payload byte sent: append the inverted CRC, MSB of register first.
                            state_reg      <= ST_CRC;
                            bit_idx_reg    <= '0;
                            tx_out_bit_reg <= ~crc_value[15];
                        end else if (byte_valid) begin
                            state_reg      <= ST_DATA;
                            bit_idx_reg    <= '0;
                            shift_reg      <= byte_data[7:1];
                            last_reg       <= byte_last;
                            tx_out_bit_reg <= byte_data[0];
                        end else begin
                            // Source starved: abandon the payload, no CRC, close the packet.
                            underrun_reg   <= 1'b1;
                            state_reg      <= ST_EOP;
                            bit_idx_reg    <= '0;
                            create_eop_reg <= 1'b1;
                            tx_out_bit_reg <= 1'b1;
                        end
                    end
                end

                ST_CRC: begin
                    if (tx_shift_reg) begin
                        if (bit_idx_reg == CRC_LAST_IDX) begin
                            state_reg      <= ST_EOP;
                            bit_idx_reg    <= '0;
                            create_eop_reg <= 1'b1;
                            tx_out_bit_reg <= 1'b1;
                        end else begin
                            bit_idx_reg    <= bit_idx_reg + 4'd1;
                            tx_out_bit_reg <= ~crc_value[4'd14 - bit_idx_reg];
                        end
                    end
                end

                ST_EOP: begin
                    // Three bit slots (SE0, SE0, J) are paced here; the encoder drives the line levels.
                    if (tx_shift_reg) begin
                        if (bit_idx_reg == EOP_LAST_IDX) begin
                            state_reg   <= ST_EOP_WAIT;
                            bit_idx_reg <= '0;
                            done_reg    <= 1'b1;
                            busy_reg    <= 1'b0;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 4'd1;
                        end
                    end
                end

                ST_EOP_WAIT: begin
                    // Done is visible this clock; a start seen now is ignored.
                    state_reg   <= ST_IDLE;
                    timer_reg   <= '0;
                    bit_idx_reg <= '0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_out_bit = tx_out_bit_reg;
    assign tx_shift   = tx_shift_reg;
    assign byte_ready = byte_ready_reg;
    assign create_eop = create_eop_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign underrun   = underrun_reg;

endmodule

// File: tb/tb_usb_tx_controller.sv
// Bench for usb_tx_controller: table of packets, expected wire bits queued
// per packet and popped on every tx_shift, plus reset and hold sequences.
module tb_usb_tx_controller;

    localparam int BIT_CLKS = 8;

    logic       tb_clk;
    logic       rst;
    logic       start;
    logic [3:0] pid;
    logic       has_data;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;
    logic       tx_hold;
    logic       tx_out_bit;
    logic       tx_shift;
    logic       create_eop;
    logic       busy;
    logic       done;
    logic       underrun;

    usb_tx_controller #(.BIT_CLKS(BIT_CLKS)) dut (
        .clk        (tb_clk),
        .rst        (rst),
        .start      (start),
        .pid        (pid),
        .has_data   (has_data),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .tx_hold    (tx_hold),
        .tx_out_bit (tx_out_bit),
        .tx_shift   (tx_shift),
        .create_eop (create_eop),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    int cyc = 0;
    always @(posedge tb_clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [3:0]  pid;
        logic        hd;
        int          nbytes;
        logic [31:0] bytes;      // byte 0 in [7:0]
        logic        under;      // source stops after nbytes without byte_last
        logic        hold;       // tx_hold across one expiry in PID bit 3
        logic        hold_start; // keep start high for the whole packet
        int          exp_shifts;
        int          exp_ready;
    } vec_t;

    vec_t vecs[7];

    int n_checks = 0;
    int n_pass   = 0;

    int exp_q[$];   // 0/1 expected wire bit, 2 = EOP slot
    int cur_i;

    int shift_cnt, eop_cnt, done_cnt, under_cnt, ready_cnt;
    int start_cyc, first_lat, last_shift_cyc, long_gaps, bad_gaps;
    int hold_on_cyc = 0, hold_off_cyc = 0;
    bit hold_req = 0;

    logic [31:0] feed_bytes;
    int          feed_n, feed_idx;
    bit          feed_last_ok;

    logic prev_bit = 1'b1, prev_shift = 1'b0, prev_busy = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic present_byte();
        if (feed_idx < feed_n) begin
            byte_valid = 1'b1;
            byte_data  = feed_bytes[feed_idx*8 +: 8];
            byte_last  = feed_last_ok && (feed_idx == feed_n - 1);
        end else begin
            byte_valid = 1'b0;
            byte_data  = 8'h00;
            byte_last  = 1'b0;
        end
    endtask

    // Byte source: advance to the next byte after each consuming clock.
    initial begin
        forever begin
            @(negedge tb_clk);
            if (byte_ready === 1'b1) begin
                ready_cnt++;
                @(posedge tb_clk);
                #1;
                feed_idx++;
                present_byte();
            end
        end
    end

    // Output monitor: pulse counts, bit scoreboard, bit timing, tx_hold drive.
    initial begin
        int v;
        int gap;
        forever begin
            @(negedge tb_clk);
            tx_hold = (cyc >= hold_on_cyc) && (cyc < hold_off_cyc);
            if (create_eop === 1'b1) eop_cnt++;
            if (done === 1'b1) done_cnt++;
            if (underrun === 1'b1) under_cnt++;
            if (tx_shift === 1'b1) begin
                shift_cnt++;
                if (first_lat < 0) first_lat = cyc - start_cyc;
                if (last_shift_cyc >= 0) begin
                    gap = cyc - last_shift_cyc;
                    if (gap == 2 * BIT_CLKS) long_gaps++;
                    else if (gap != BIT_CLKS) bad_gaps++;
                end
                last_shift_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_shift", int'(tx_shift), 0);
                end else begin
                    v = exp_q.pop_front();
                    if (v == 2) check($sformatf("%s_eop_before_slot", vecs[cur_i].name), eop_cnt, 1);
                    else check($sformatf("%s_bit%0d", vecs[cur_i].name, shift_cnt - 1), int'(tx_out_bit), v);
                end
                if (hold_req && shift_cnt == 11) begin
                    hold_req     = 0;
                    hold_on_cyc  = cyc + 3;
                    hold_off_cyc = cyc + 11;
                end
            end
            if (rst !== 1'b1 && prev_busy && tx_out_bit !== prev_bit && !prev_shift)
                check("bit_stable", int'(tx_out_bit), int'(prev_bit));
            prev_bit   = tx_out_bit;
            prev_shift = tx_shift;
            prev_busy  = busy;
        end
    end

    task automatic start_vec(input int i);
        logic [7:0]  b;
        logic [15:0] crc;
        logic        fb;
        cur_i        = i;
        feed_bytes   = vecs[i].bytes;
        feed_n       = vecs[i].nbytes;
        feed_idx     = 0;
        feed_last_ok = !vecs[i].under;
        present_byte();
        exp_q.delete();
        b = 8'h80;
        for (int k = 0; k < 8; k++) exp_q.push_back(int'(b[k]));
        b = {~vecs[i].pid, vecs[i].pid};
        for (int k = 0; k < 8; k++) exp_q.push_back(int'(b[k]));
        if (vecs[i].hd) begin
            crc = 16'hFFFF;
            for (int j = 0; j < vecs[i].nbytes; j++) begin
                b = vecs[i].bytes[j*8 +: 8];
                for (int k = 0; k < 8; k++) begin
                    exp_q.push_back(int'(b[k]));
                    fb  = crc[0] ^ b[k];
                    crc = crc >> 1;
                    if (fb) crc = crc ^ 16'hA001;
                end
            end
            if (!vecs[i].under) begin
                crc = ~crc;
                for (int k = 0; k < 16; k++) exp_q.push_back(int'(crc[k]));
            end
        end
        for (int k = 0; k < 3; k++) exp_q.push_back(2);
        shift_cnt = 0; eop_cnt = 0; done_cnt = 0; under_cnt = 0; ready_cnt = 0;
        first_lat = -1; last_shift_cyc = -1; long_gaps = 0; bad_gaps = 0;
        hold_req = vecs[i].hold;
        @(negedge tb_clk);
        pid      = vecs[i].pid;
        has_data = vecs[i].hd;
        start    = 1'b1;
        @(posedge tb_clk);
        #1;
        start_cyc = cyc;
        if (!vecs[i].hold_start) start = 1'b0;
        check($sformatf("%s_busy_after_start", vecs[i].name), int'(busy), 1);
    endtask

    task automatic finish_vec(input int i);
        for (int c = 0; c < 4000 && done !== 1'b1; c++) @(negedge tb_clk);
        if (vecs[i].hold_start) begin
            @(negedge tb_clk);
            start = 1'b0;
        end
        repeat (BIT_CLKS + 4) @(negedge tb_clk);
        check($sformatf("%s_shifts", vecs[i].name), shift_cnt, vecs[i].exp_shifts);
        check($sformatf("%s_create_eop", vecs[i].name), eop_cnt, 1);
        check($sformatf("%s_done", vecs[i].name), done_cnt, 1);
        check($sformatf("%s_underrun", vecs[i].name), under_cnt, int'(vecs[i].under));
        check($sformatf("%s_byte_ready", vecs[i].name), ready_cnt, vecs[i].exp_ready);
        check($sformatf("%s_first_shift", vecs[i].name), first_lat, BIT_CLKS);
        check($sformatf("%s_held_gaps", vecs[i].name), long_gaps, int'(vecs[i].hold));
        check($sformatf("%s_bad_gaps", vecs[i].name), bad_gaps, 0);
        check($sformatf("%s_bits_left", vecs[i].name), exp_q.size(), 0);
        check($sformatf("%s_busy_end", vecs[i].name), int'(busy), 0);
        $display("packet %s: shifts=%0d eop=%0d done=%0d underrun=%0d ready=%0d held_gaps=%0d",
                 vecs[i].name, shift_cnt, eop_cnt, done_cnt, under_cnt, ready_cnt, long_gaps);
    endtask

    initial begin
        int snap;
        vecs[0] = '{"ack",       4'b0010, 1'b0, 0, 32'h0,        1'b0, 1'b0, 1'b0, 19, 0};
        vecs[1] = '{"data0_00",  4'b0011, 1'b1, 1, 32'h0,        1'b0, 1'b0, 1'b0, 43, 1};
        vecs[2] = '{"data1_3b",  4'b1011, 1'b1, 3, 32'h00030201, 1'b0, 1'b0, 1'b0, 59, 3};
        vecs[3] = '{"underrun",  4'b0011, 1'b1, 1, 32'h0000005A, 1'b1, 1'b0, 1'b0, 27, 2};
        vecs[4] = '{"nak_start", 4'b1010, 1'b0, 0, 32'h0,        1'b0, 1'b0, 1'b1, 19, 0};
        vecs[5] = '{"ack_hold",  4'b0010, 1'b0, 0, 32'h0,        1'b0, 1'b1, 1'b0, 19, 0};
        vecs[6] = '{"data0_2b",  4'b0011, 1'b1, 2, 32'h00005AA5, 1'b0, 1'b0, 1'b0, 51, 2};

        rst = 1'b1; start = 1'b0; pid = 4'h0; has_data = 1'b0;
        byte_data = 8'h00; byte_valid = 1'b0; byte_last = 1'b0; tx_hold = 1'b0;
        repeat (3) @(posedge tb_clk);
        #1;
        check("rst_tx_out_bit", int'(tx_out_bit), 1);
        check("rst_tx_shift", int'(tx_shift), 0);
        check("rst_create_eop", int'(create_eop), 0);
        check("rst_byte_ready", int'(byte_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_underrun", int'(underrun), 0);
        $display("reset: tx_out_bit=%0d busy=%0d", tx_out_bit, busy);
        @(negedge tb_clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            start_vec(i);
            finish_vec(i);
        end

        // Reset in the middle of the payload aborts without EOP or done.
        start_vec(2);
        for (int c = 0; c < 2000 && shift_cnt < 20; c++) @(negedge tb_clk);
        rst = 1'b1;
        @(posedge tb_clk);
        #1;
        check("midrst_tx_out_bit", int'(tx_out_bit), 1);
        check("midrst_tx_shift", int'(tx_shift), 0);
        check("midrst_create_eop", int'(create_eop), 0);
        check("midrst_byte_ready", int'(byte_ready), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_underrun", int'(underrun), 0);
        @(negedge tb_clk);
        @(negedge tb_clk);
        rst = 1'b0;
        exp_q.delete();
        snap = shift_cnt;
        done_cnt = 0;
        eop_cnt = 0;
        repeat (4 * BIT_CLKS) @(negedge tb_clk);
        check("midrst_no_shift", shift_cnt, snap);
        check("midrst_no_done", done_cnt, 0);
        check("midrst_no_eop", eop_cnt, 0);
        check("midrst_idle", int'(busy), 0);
        $display("mid-packet reset: shifts_before=%0d done=%0d eop=%0d", snap, done_cnt, eop_cnt);

        start_vec(6);
        finish_vec(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
